// File: rtl/an_decode_sequencer.sv
// AN-code (A=29) decoder: serial residue check, optional single-bit fix, serial divide by A.
// Single-bit correction stage is built only when ANDEC_CORRECT_EN is defined.
module an_decode_sequencer #(
  parameter int A   = 29,
  parameter int WAN = 28,
  parameter int WN  = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WAN-1:0] ANe,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WN-1:0]  Nc,
  output logic           err_corr,
  output logic           err_uncorr,
  output logic           err_range,
  output logic           busy
);
  localparam int RW = $clog2(A);
  localparam int CW = $clog2(WAN + 1);
  localparam int IW = $clog2(WAN);

  typedef enum logic [2:0] {
    IDLE,
    RESID,
`ifdef ANDEC_CORRECT_EN
    CORRECT,
`endif
    DIVIDE,
    OUT
  } state_t;

  state_t         state_q, state_d;
  logic [WAN-1:0] w_q, w_d;
  logic [WAN-1:0] q_q, q_d;
  logic [RW-1:0]  r_q, r_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           unc_q, unc_d;
  logic [WN-1:0]  nc_q, nc_d;
  logic           err_uncorr_q, err_uncorr_d;
  logic           err_range_q, err_range_d;

  logic [IW-1:0]  bit_idx;
  logic           cur_bit;
  logic [RW:0]    r_trial, r_red;
  logic [RW:0]    d_trial, d_red;
  logic           q_bit;

`ifdef ANDEC_CORRECT_EN
  // 2^k mod 29 for k = 0..27; a nonzero residue identifies the flipped bit position
  localparam logic [RW-1:0] POW_TBL [WAN] = '{
    5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd3,  5'd6,  5'd12, 5'd24, 5'd19,
    5'd9,  5'd18, 5'd7,  5'd14, 5'd28, 5'd27, 5'd25, 5'd21, 5'd13, 5'd26,
    5'd23, 5'd17, 5'd5,  5'd10, 5'd20, 5'd11, 5'd22, 5'd15
  };
  logic          corr_q, corr_d;
  logic          err_corr_q, err_corr_d;
  logic [IW-1:0] k_sel, j_sel;
  logic [IW:0]   j_sum;

  always_comb begin
    k_sel = '0;
    for (int k = 0; k < WAN; k++) begin
      if (POW_TBL[k] == r_q) k_sel = IW'(k);
    end
    j_sum = {1'b0, k_sel} + (IW+1)'(WAN / 2);
    if (j_sum >= (IW+1)'(WAN)) j_sum = j_sum - (IW+1)'(WAN);
    j_sel = j_sum[IW-1:0];
  end
`endif

  assign bit_idx = IW'(WAN - 1) - IW'(cnt_q);
  assign cur_bit = w_q[bit_idx];
  assign r_trial = {r_q, cur_bit};
  assign r_red   = (r_trial >= (RW+1)'(A)) ? r_trial - (RW+1)'(A) : r_trial;
  assign d_trial = {rem_q, cur_bit};
  assign q_bit   = (d_trial >= (RW+1)'(A));
  assign d_red   = q_bit ? d_trial - (RW+1)'(A) : d_trial;

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    q_d          = q_q;
    r_d          = r_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    unc_d        = unc_q;
    nc_d         = nc_q;
    err_uncorr_d = err_uncorr_q;
    err_range_d  = err_range_q;
`ifdef ANDEC_CORRECT_EN
    corr_d       = corr_q;
    err_corr_d   = err_corr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d     = ANe;
          q_d     = '0;
          r_d     = '0;
          rem_d   = '0;
          cnt_d   = '0;
          unc_d   = 1'b0;
`ifdef ANDEC_CORRECT_EN
          corr_d  = 1'b0;
`endif
          state_d = RESID;
        end
      end
      RESID: begin
        r_d   = r_red[RW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WAN - 1)) begin
          cnt_d   = '0;
`ifdef ANDEC_CORRECT_EN
          state_d = CORRECT;
`else
          unc_d   = (r_red[RW-1:0] != '0);
          state_d = DIVIDE;
`endif
        end
      end
`ifdef ANDEC_CORRECT_EN
      CORRECT: begin
        if (r_q != '0) begin
          if (w_q[k_sel]) begin
            w_d[k_sel] = 1'b0;
            corr_d     = 1'b1;
          end else if (!w_q[j_sel]) begin
            w_d[j_sel] = 1'b1;
            corr_d     = 1'b1;
          end else begin
            unc_d      = 1'b1;
          end
        end
        state_d = DIVIDE;
      end
`endif
      DIVIDE: begin
        // One extra cycle after the last quotient bit to latch results
        if (cnt_q == CW'(WAN)) begin
          nc_d         = unc_q ? '0 : q_q[WN-1:0];
          err_range_d  = unc_q ? 1'b0 : |q_q[WAN-1:WN];
          err_uncorr_d = unc_q;
`ifdef ANDEC_CORRECT_EN
          err_corr_d   = corr_q;
`endif
          state_d      = OUT;
        end else begin
          rem_d = d_red[RW-1:0];
          q_d   = {q_q[WAN-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      q_q          <= '0;
      r_q          <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      unc_q        <= 1'b0;
      nc_q         <= '0;
      err_uncorr_q <= 1'b0;
      err_range_q  <= 1'b0;
`ifdef ANDEC_CORRECT_EN
      corr_q       <= 1'b0;
      err_corr_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      q_q          <= q_d;
      r_q          <= r_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      unc_q        <= unc_d;
      nc_q         <= nc_d;
      err_uncorr_q <= err_uncorr_d;
      err_range_q  <= err_range_d;
`ifdef ANDEC_CORRECT_EN
      corr_q       <= corr_d;
      err_corr_q   <= err_corr_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == OUT);
  assign Nc         = nc_q;
  assign err_uncorr = err_uncorr_q;
  assign err_range  = err_range_q;
`ifdef ANDEC_CORRECT_EN
  assign err_corr   = err_corr_q;
`else
  assign err_corr   = 1'b0;
`endif

endmodule

// File: tb/tb_an_decode_sequencer.sv
// Scoreboard bench for an_decode_sequencer; expectations follow ANDEC_CORRECT_EN when defined.
module tb_an_decode_sequencer;
`ifdef ANDEC_CORRECT_EN
  localparam int LAT = 58;
`else
  localparam int LAT = 57;
`endif

  typedef struct packed {
    logic [22:0] nc;
    logic        corr;
    logic        unc;
    logic        rng;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [27:0] ANe = '0;
  logic        in_ready, out_valid, err_corr, err_uncorr, err_range, busy;
  logic [22:0] Nc;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  an_decode_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ANe(ANe),
    .out_valid(out_valid), .out_ready(out_ready), .Nc(Nc), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .err_range(err_range), .busy(busy)
  );

  function automatic exp_t mk(input logic [22:0] nc, input logic c, input logic u, input logic r);
    exp_t e;
    e.nc = nc; e.corr = c; e.unc = u; e.rng = r; e.lat = 8'(LAT);
    return e;
  endfunction

  function automatic exp_t model(input logic [27:0] w);
    exp_t        e;
    logic [27:0] ww;
    logic [27:0] q;
    int          r, k, j, p;
    e  = mk('0, 1'b0, 1'b0, 1'b0);
    ww = w;
    r  = int'(w % 28'd29);
    if (r != 0) begin
`ifdef ANDEC_CORRECT_EN
      k = 0; p = 1;
      for (int i = 0; i < 28; i++) begin
        if (p == r) k = i;
        p = (p * 2) % 29;
      end
      j = (k + 14) % 28;
      if (ww[k]) begin ww[k] = 1'b0; e.corr = 1'b1; end
      else if (!ww[j]) begin ww[j] = 1'b1; e.corr = 1'b1; end
      else e.unc = 1'b1;
`else
      e.unc = 1'b1;
`endif
    end
    if (!e.unc) begin
      q     = ww / 28'd29;
      e.nc  = q[22:0];
      e.rng = |q[27:23];
    end
    return e;
  endfunction

  task automatic run_word(input logic [27:0] ane, input exp_t e, input int hold, input string name);
    int   n;
    exp_t x;
    sb.push_back(e);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_ready: got %b want 1", name, in_ready);
    end
    in_valid  = 1'b1;
    ANe       = ane;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    ANe = 28'($urandom);
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++; $display("FAIL %s busy_ready: got %b want 10", name, {busy, in_ready});
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    x = sb.pop_front();
    checks++;
    if (n !== int'(x.lat)) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, n, x.lat);
    end
    checks++;
    if (Nc !== x.nc) begin
      errors++; $display("FAIL %s Nc: got %0d want %0d", name, Nc, x.nc);
    end
    checks++;
    if ({err_corr, err_uncorr, err_range} !== {x.corr, x.unc, x.rng}) begin
      errors++; $display("FAIL %s flags(c,u,r): got %b want %b", name,
                         {err_corr, err_uncorr, err_range}, {x.corr, x.unc, x.rng});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, Nc, err_corr, err_uncorr, err_range} !==
          {1'b1, 1'b0, x.nc, x.corr, x.unc, x.rng}) begin
        errors++; $display("FAIL %s hold%0d: got v=%b rdy=%b Nc=%0d f=%b want v=1 rdy=0 Nc=%0d f=%b",
                           name, i, out_valid, in_ready, Nc, {err_corr, err_uncorr, err_range},
                           x.nc, {x.corr, x.unc, x.rng});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s release: got v/rdy=%b want 01", name, {out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, Nc, err_corr, err_uncorr, err_range} !== {1'b1, 1'b0, 1'b0, 23'd0, 3'b000}) begin
      errors++; $display("FAIL reset_state: got rdy=%b v=%b busy=%b Nc=%0d f=%b want rdy=1 others 0",
                         in_ready, out_valid, busy, Nc, {err_corr, err_uncorr, err_range});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    run_word(28'd29000, mk(23'd1000, 1'b0, 1'b0, 1'b0), 0, "clean");
    run_word(28'd0, model(28'd0), 0, "zero");
  endtask

  task automatic test_single_error();
`ifdef ANDEC_CORRECT_EN
    run_word(28'd28992, mk(23'd1000, 1'b1, 1'b0, 1'b0), 0, "single_err");
`else
    run_word(28'd28992, mk(23'd0, 1'b0, 1'b1, 1'b0), 0, "single_err");
`endif
  endtask

  task automatic test_uncorrectable();
    run_word(28'd29022, mk(23'd0, 1'b0, 1'b1, 1'b0), 0, "uncorr");
  endtask

  task automatic test_range();
    run_word(28'd243269632, mk(23'd0, 1'b0, 1'b0, 1'b1), 0, "range");
    run_word(28'hFFFFFFF, model(28'hFFFFFFF), 0, "all_ones");
  endtask

  task automatic test_backpressure();
    run_word(28'd29000, mk(23'd1000, 1'b0, 1'b0, 1'b0), 10, "backpressure");
  endtask

  task automatic test_back_to_back();
    logic [27:0] w;
    for (int i = 0; i < 6; i++) begin
      w = 28'($urandom_range(0, 8388607)) * 28'd29;
      if (i % 2 == 1) w[$urandom_range(0, 27)] ^= 1'b1;
      run_word(w, model(w), (i == 3) ? 3 : 0, "b2b");
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    run_word(28'd58000, mk(23'd2000, 1'b0, 1'b0, 1'b0), 0, "pre_abort");
    in_valid = 1'b1;
    ANe      = 28'd29022;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, Nc, err_corr, err_uncorr, err_range} !== {1'b1, 1'b0, 1'b0, 23'd0, 3'b000}) begin
      errors++; $display("FAIL abort_reset_state: got rdy=%b v=%b busy=%b Nc=%0d f=%b want rdy=1 others 0",
                         in_ready, out_valid, busy, Nc, {err_corr, err_uncorr, err_range});
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    run_word(28'd29000, mk(23'd1000, 1'b0, 1'b0, 1'b0), 0, "post_abort");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_uncorrectable();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/an_decode_sequencer.md
AN_DECODE_SEQUENCER -- requirements
Module: an_decode_sequencer

Interface
REQ-001 Parameter: A, 29, AN-code multiplier; the fixed tables below are valid only for 29.
REQ-002 Parameter: WAN, 28, coded word width.
REQ-003 Parameter: WN, 23, decoded data width.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: in_valid  input  1  ANe word offered.
REQ-007 Port: in_ready  output  1  block accepts word; high only in IDLE.
REQ-008 Port: ANe  input  WAN  received AN-coded word.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: Nc  output  WN  decoded data.
REQ-012 Port: err_corr  output  1  single-bit error corrected.
REQ-013 Port: err_uncorr  output  1  uncorrectable word.
REQ-014 Port: err_range  output  1  quotient exceeds WN bits.
REQ-015 Port: busy  output  1  state is not IDLE.

Function
REQ-016 States: IDLE, RESID, CORRECT, DIVIDE, OUT.
REQ-017 IDLE: on in_valid && in_ready, the block registers ANe into word register W and goes to RESID.
REQ-018 RESID: one bit per cycle, MSB first, for WAN cycles: r = (2r + W[i]) mod 29, with r held in 5 bits and cleared on entry.
REQ-019 If r == 0 after RESID, W is unchanged and no flag is set.
REQ-020 If r != 0, k is the unique index with 2^k mod 29 == r, and j = (k+14) mod 28.
REQ-021 If W[k] == 1, clear W[k] and set err_corr.
REQ-022 Else if W[j] == 0, set W[j] and set err_corr.
REQ-023 Else, set err_uncorr and leave W unchanged.
REQ-024 The k lookup is a fixed 28-entry table: 1,2,4,8,16,3,6,12,24,19,9,18,7,14,28,27,25,21,13,26,23,17,5,10,20,11,22,15 for k=0..27.
REQ-025 DIVIDE: restoring division of W by 29, one quotient bit per cycle, WAN cycles, producing a 28-bit quotient q.
REQ-026 Nc = q[WN-1:0], and err_range = |q[WAN-1:WN].
REQ-027 When err_uncorr = 1, Nc = 0 and err_range = 0; the DIVIDE cycles are still spent, so latency is constant.
REQ-028 Latency: out_valid rises exactly 58 clk edges after the accept edge (28 RESID + 1 CORRECT + 28 DIVIDE + 1).
REQ-029 OUT: Nc and all flags are held stable while out_valid && !out_ready.
REQ-030 On out_valid && out_ready, the block returns to IDLE; in_ready rises the next cycle.
REQ-031 No overlap: a new word is not accepted in the same cycle as a result is consumed.
REQ-032 in_valid is ignored outside IDLE; ANe changes after acceptance have no effect.
REQ-033 err_corr and err_uncorr are mutually exclusive; err_range can accompany err_corr.
REQ-034 Flags and Nc are updated only on the transition into OUT; they are otherwise held.

Reset
REQ-035 While rst = 1: state = IDLE, and W, r, q, Nc, err_corr, err_uncorr, err_range, out_valid and busy are all 0; in_ready = 1.
REQ-036 Reset asserted mid-operation aborts the word immediately; no out_valid is produced for it.

Configuration
REQ-037 Macro ANDEC_CORRECT_EN.
REQ-038 With ANDEC_CORRECT_EN defined: behaviour is as in REQ-020 to REQ-024; latency is 58.
REQ-039 Without ANDEC_CORRECT_EN: the CORRECT state and the lookup table are absent; any r != 0 sets err_uncorr with Nc = 0; err_corr is tied to 0; latency is 57.

Verification
REQ-040 Clean word: ANe=29000, out_ready=1 -> Nc=1000, all flags 0, out_valid at edge 58.
REQ-041 Single error: ANe=28992 (bit 3 cleared) -> residue 21, k=17, j=3 set -> Nc=1000, err_corr=1. Without the macro: err_uncorr=1, Nc=0, latency 57.
REQ-042 Uncorrectable: ANe=29022 -> residue 22, k=26 (bit 26=0), j=12 (bit 12=1) -> err_uncorr=1, Nc=0.
REQ-043 Range: ANe=243269632 (29*2^23) -> err_range=1, Nc=0, err_corr=0.
REQ-044 Backpressure and reset:
- out_ready low for 10 cycles -> Nc and flags stable, in_ready=0.
- rst pulse at cycle 20 of RESID -> no out_valid; the next word, 29000, decodes to Nc=1000.
